// File: rtl/adder_entry_fsm.sv
// Two-operand entry controller: successive step pulses capture A then B from the switches,
// then one ADD cycle registers A+B with carry/overflow and holds it for display until the next step.
module adder_entry_fsm #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    input  logic             clr,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH:0]   sum_out,
    output logic             carry_out,
    output logic             ovf_out,
    output logic             sum_valid,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_have_a = 2'd1;
    localparam logic [1:0] st_add    = 2'd2;
    localparam logic [1:0] st_show   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   add_res;
    logic             add_ovf;

    // Signed overflow: operands share a sign that the truncated result does not.
    assign add_res = {1'b0, a_q} + {1'b0, b_q};
    assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (clr) begin
            // Clear drops any in-flight entry but keeps the completed-operation tally.
            state_d = st_idle;
            a_d     = '0;
            b_d     = '0;
            sum_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                st_idle: begin
                    if (step) begin
                        a_d     = sw;
                        state_d = st_have_a;
                    end
                end
                st_have_a: begin
                    if (step) begin
                        b_d     = sw;
                        state_d = st_add;
                    end
                end
                st_add: begin
                    sum_d   = add_res;
                    ovf_d   = add_ovf;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = st_show;
                end
                st_show: begin
                    if (step) begin
                        valid_d = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = st_idle;
                    end
                end
                default: state_d = st_idle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= st_idle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign sum_out   = sum_q;
    assign carry_out = sum_q[WIDTH];
    assign ovf_out   = ovf_q;
    assign sum_valid = valid_q;
    assign state_out = state_q;
    assign op_count  = cnt_q;

endmodule
